// File: rtl/instr_cycle_sequencer.sv
// Instruction cycle sequencer: steps through the 5/7/12-cycle instruction timing and tracks the halted state.
// Optional retired-instruction counter is compiled in when INSTR_CYCLE_TRACE_EN is defined.
module instr_cycle_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  length,
  input  logic        halt,
  input  logic        wake,
  output logic [1:0]  phase,
  output logic        step,
  output logic [3:0]  cycle,
  output logic        busy,
  output logic        done,
  output logic        halted,
  output logic [15:0] retired_count
);

  localparam int unsigned LEN_W = 2;
  localparam int unsigned CYC_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] PH_NONE  = 2'd0;
  localparam logic [1:0] PH_FETCH = 2'd1;
  localparam logic [1:0] PH_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [CYC_W-1:0] last_cyc;
  logic             is_last;

  // Total cycle count of the latched instruction; the reserved encoding runs as CYCLE5.
  always_comb begin
    last_cyc = CYC_W'(5);
    case (len_q)
      2'd1:    last_cyc = CYC_W'(7);
      2'd2:    last_cyc = CYC_W'(12);
      default: last_cyc = CYC_W'(5);
    endcase
  end

  assign is_last = (cycle_q == last_cyc);

  // Status decode from the held state.
  always_comb begin
    busy   = (state_q == ST_RUN);
    halted = (state_q == ST_HALTED);
    done   = busy && is_last;
    cycle  = cycle_q;
    step   = busy && (len_q == 2'd2) && (cycle_q >= CYC_W'(7));
    phase  = PH_NONE;
    if (busy) begin
      if (len_q == 2'd2) begin
        if ((cycle_q == CYC_W'(2)) || (cycle_q == CYC_W'(7))) begin
          phase = PH_FETCH;
        end else if ((cycle_q == CYC_W'(6)) || (cycle_q == CYC_W'(11))) begin
          phase = PH_WRITE;
        end
      end else begin
        if (cycle_q == CYC_W'(2)) begin
          phase = PH_FETCH;
        end else if (cycle_q == (last_cyc - CYC_W'(1))) begin
          phase = PH_WRITE;
        end
      end
    end
  end

  // Next-state logic; nothing moves on a disabled edge.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    len_d   = len_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            len_d   = length;
            cycle_d = CYC_W'(1);
          end else if (halt) begin
            state_d = ST_HALTED;
          end
        end
        ST_RUN: begin
          if (is_last) begin
            if (start) begin
              len_d   = length;
              cycle_d = CYC_W'(1);
            end else begin
              state_d = ST_IDLE;
              cycle_d = '0;
            end
          end else begin
            cycle_d = cycle_q + CYC_W'(1);
          end
        end
        ST_HALTED: begin
          if (wake) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cycle_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      len_q   <= len_d;
    end
  end

`ifdef INSTR_CYCLE_TRACE_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Counts completed instructions; wraps naturally at 16 bits.
  always_comb begin
    retired_d = retired_q;
    if (clk_en && done) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Self-checking bench for instr_cycle_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_instr_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, clk_en, start, halt, wake;
  logic [1:0]  length;
  logic [1:0]  phase;
  logic        step, busy, done, halted;
  logic [3:0]  cycle;
  logic [15:0] retired_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0=idle, 1=running, 2=halted.
  int m_mode;
  int m_cycle;
  int m_total;
  int m_retired;
  int n_of_len [4] = '{5, 7, 12, 5};

  always #5 clk = ~clk;

  instr_cycle_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_en       (clk_en),
    .start        (start),
    .length       (length),
    .halt         (halt),
    .wake         (wake),
    .phase        (phase),
    .step         (step),
    .cycle        (cycle),
    .busy         (busy),
    .done         (done),
    .halted       (halted),
    .retired_count(retired_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_phase();
    int c;
    c = m_cycle;
    if (m_mode != 1) return 0;
    if (m_total == 12) begin
      if (c == 2 || c == 7)  return 1;
      if (c == 6 || c == 11) return 2;
      return 0;
    end
    if (c == 2)           return 1;
    if (c == m_total - 1) return 2;
    return 0;
  endfunction

  function automatic bit exp_done();
    return (m_mode == 1) && (m_cycle == m_total);
  endfunction

  task automatic check_all();
    check_eq("busy",   32'(busy),   32'(m_mode == 1));
    check_eq("halted", 32'(halted), 32'(m_mode == 2));
    check_eq("cycle",  32'(cycle),  32'(m_cycle));
    check_eq("done",   32'(done),   32'(exp_done()));
    check_eq("step",   32'(step),   32'((m_mode == 1) && (m_total == 12) && (m_cycle > 6)));
    check_eq("phase",  32'(phase),  32'(exp_phase()));
`ifdef INSTR_CYCLE_TRACE_EN
    check_eq("retired", 32'(retired_count), 32'(m_retired & 16'hFFFF));
`else
    check_eq("retired", 32'(retired_count), 32'd0);
`endif
  endtask

  // Apply one clock with the given inputs, advance the model, then check at the falling edge.
  task automatic tick(input bit en, input bit st, input int len, input bit hl, input bit wk, input bit rn);
    bit was_done;
    clk_en  = en;
    start   = st;
    length  = 2'(len);
    halt    = hl;
    wake    = wk;
    reset_n = rn;
    @(posedge clk);
    was_done = exp_done();
    if (!rn) begin
      m_mode = 0; m_cycle = 0; m_total = 5; m_retired = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (st) begin
          m_mode = 1; m_cycle = 1; m_total = n_of_len[len];
        end else if (hl) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (was_done) begin
          m_retired++;
          if (st) begin
            m_cycle = 1; m_total = n_of_len[len];
          end else begin
            m_mode = 0; m_cycle = 0;
          end
        end else begin
          m_cycle++;
        end
      end else if (wk) begin
        m_mode = 0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_mode = 0; m_cycle = 0; m_total = 5; m_retired = 0;
    @(negedge clk);
    // Reset is honoured even with the clock enable low.
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 2, 1, 0, 0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // 5-cycle instruction: done on the 5th cycle, idle on the next.
    tick(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 3, 0, 0, 1);
    check_eq("c5_done", 32'(done), 32'd1);
    tick(1, 0, 0, 0, 0, 1);
    check_eq("c5_idle", 32'(busy), 32'd0);

    // 12-cycle instruction, with length wiggling mid-flight.
    tick(1, 1, 2, 0, 0, 1);
    for (int i = 0; i < 11; i++) tick(1, 1, i % 4, 1, 0, 1);
    check_eq("c12_done", 32'(done), 32'd1);
    tick(1, 0, 0, 0, 0, 1);

    // Back-to-back: 7-cycle instruction reloaded into a 5-cycle one.
    tick(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 1);
    check_eq("b2b_cycle", 32'(cycle), 32'd1);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0, 1);
    check_eq("b2b_done", 32'(done), 32'd1);
    tick(1, 0, 0, 0, 0, 1);

    // Alternating clock enable stretches the instruction.
    tick(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) tick(i % 2 == 1, 1, 2, 1, 1, 1);
    check_eq("gate_done", 32'(done), 32'd1);
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);

    // Halt, ignored start, wake, then a 7-cycle instruction.
    tick(1, 0, 0, 1, 0, 1);
    check_eq("halt_on", 32'(halted), 32'd1);
    tick(1, 1, 2, 1, 0, 1);
    tick(1, 0, 0, 0, 1, 1);
    tick(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, 1);
    check_eq("wake_done", 32'(done), 32'd1);
    tick(1, 0, 0, 0, 0, 1);

    // Reset mid-instruction drops everything with no done.
    tick(1, 1, 2, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    check_eq("rst_mid_cycle", 32'(cycle), 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 99) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_cycle_sequencer.md
INSTR_CYCLE_SEQUENCER -- requirements
Module: instr_cycle_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: clk_en  input  1  CPU clock enable; state advances only on edges with clk_en=1.
REQ-004 SHALL have port: start  input  1  decoder pulse: new instruction decoded, begin sequencing.
REQ-005 SHALL have port: length  input  2  instr_length encoding: 0=CYCLE5, 1=CYCLE7, 2=CYCLE12, 3=reserved.
REQ-006 SHALL have port: halt  input  1  HALT/SLP instruction retired; enter halted state.
REQ-007 SHALL have port: wake  input  1  interrupt pending; leave halted state.
REQ-008 SHALL have port: phase  output  2  microcode_cycle encoding: 0=CYCLE_NONE, 1=CYCLE_REG_FETCH, 2=CYCLE_REG_WRITE.
REQ-009 SHALL have port: step  output  1  micro-op index within the instruction (0 first, 1 second; CYCLE12 only).
REQ-010 SHALL have port: cycle  output  4  current cycle number, 1..12; 0 when not running.
REQ-011 SHALL have port: busy  output  1  instruction in progress.
REQ-012 SHALL have port: done  output  1  one-enabled-cycle pulse on the final cycle of an instruction.
REQ-013 SHALL have port: halted  output  1  core halted.
REQ-014 SHALL have port: retired_count  output  16  retired-instruction counter (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALTED; all transitions occur only on clk_en=1 edges.
REQ-016 SHALL, in IDLE with start=1: latch length, set cycle=1, step=0, go to RUN; start has priority over halt.
REQ-017 SHALL, in IDLE with halt=1 and start=0, go to HALTED.
REQ-018 SHALL map length to a total count N: 0->5, 1->7, 2->12, 3->5 (reserved treated as CYCLE5).
REQ-019 SHALL, in RUN, increment cycle by 1 per enabled edge until cycle=N.
REQ-020 SHALL drive phase combinationally from the latched length and cycle: N=5/7: FETCH at cycle 2, WRITE at cycle N-1, else NONE.
REQ-021 SHALL for N=12: FETCH at cycles 2 and 7, WRITE at cycles 6 and 11, else NONE; step=0 for cycles 1-6, step=1 for cycles 7-12.
REQ-022 SHALL assert done combinationally while in RUN with cycle=N.
REQ-023 SHALL, at cycle=N: with start=1, reload (latch new length, cycle=1, step=0, stay in RUN, no idle gap); else go to IDLE with cycle=0.
REQ-024 SHALL ignore start in RUN when cycle != N; length changes mid-instruction SHALL NOT affect N.
REQ-025 SHALL ignore start and halt in HALTED; wake=1 returns to IDLE on the next enabled edge.
REQ-026 SHALL assert busy iff state=RUN and halted iff state=HALTED.
REQ-027 SHALL hold every register unchanged when clk_en=0; done, phase and step SHALL reflect the held state.

Reset
REQ-028 SHALL, when reset_n=0 at a rising edge regardless of clk_en, force state=IDLE, cycle=0, step=0, latched length=0, retired_count=0.
REQ-029 SHALL drive outputs during/after reset: phase=0, busy=0, done=0, halted=0, step=0, cycle=0.
REQ-030 SHALL abandon an instruction in progress on reset with no done pulse issued.

Configuration
REQ-031 SHALL compile a 16-bit retired-instruction counter only when macro INSTR_CYCLE_TRACE_EN is defined: it increments on each enabled edge with done=1 and wraps 0xFFFF->0x0000.
REQ-032 SHALL, without INSTR_CYCLE_TRACE_EN, keep the retired_count port and drive it constant 0, with no counter logic.

Verification
REQ-033 SHALL cover: clk_en=1, start with length=0 -> phase FETCH at cycle 2, WRITE at cycle 4, done at cycle 5, busy low at cycle 6.
REQ-034 SHALL cover: length=2 -> FETCH at cycles 2/7, WRITE at cycles 6/11, step rises at cycle 7, done at cycle 12.
REQ-035 SHALL cover: start held during done of a 7-cycle instruction with length=0 -> cycle goes 7->1, busy never drops, second done 5 enabled cycles later.
REQ-036 SHALL cover: clk_en toggling 1,0,1,0 -> cycle advances only on enabled edges; a 5-cycle instruction takes 10 clocks.
REQ-037 SHALL cover: halt in IDLE -> halted=1; start ignored; wake -> IDLE; then start, length=1 -> done after 7 cycles.
REQ-038 SHALL cover: reset_n=0 at cycle 3 of 12 -> all outputs 0 next edge; with INSTR_CYCLE_TRACE_EN, 0xFFFF retired + one done -> retired_count=0x0000.
